// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - multicycle 8-register accumulator-style CPU core
//
// Purpose: fetches 12-bit instructions over a valid/ready handshake and
// executes them over several cycles (FETCH, LOADA, EXEC, WB, OUTW, HALT).
// Instruction word: {op[11:9], fn[8:6], rd[5:3], rs[2:0]}.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   inst_valid/inst_data  instruction source, inst_ready high only in FETCH
//   out_valid/out_data    OUT result, held until out_ready
//   carry, zero           ALU flags, updated only in ALU write-back
//   halted                core is in HALT (left only via rst)
//   err                   sticky illegal-opcode flag
//   dbg_sel/dbg_data      combinational register-file read port
module multicycle_cpu #(
  parameter int WIDTH = 8,
  parameter int NREG  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  input  logic [11:0]      inst_data,
  output logic             inst_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             carry,
  output logic             zero,
  output logic             halted,
  output logic             err,
  input  logic [2:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_ALU  = 3'b011;
  localparam logic [2:0] OP_OUT  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;

  localparam logic [2:0] FN_ADD  = 3'b000;
  localparam logic [2:0] FN_SUB  = 3'b001;
  localparam logic [2:0] FN_AND  = 3'b010;
  localparam logic [2:0] FN_OR   = 3'b011;
  localparam logic [2:0] FN_XOR  = 3'b100;
  localparam logic [2:0] FN_SHL  = 3'b101;
  localparam logic [2:0] FN_SHR  = 3'b110;
  localparam logic [2:0] FN_PASS = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_LOADA,
    S_EXEC,
    S_WB,
    S_OUTW,
    S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [11:0]      r_inst;
  logic [WIDTH-1:0] r_regs [NREG];
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rc;
  logic             r_rc_carry;   // carry computed in EXEC, committed in WB
  logic             r_carry;
  logic             r_zero;
  logic             r_err;

  logic             w_accept;
  logic [2:0]       w_in_op;
  logic [2:0]       w_op;
  logic [2:0]       w_fn;
  logic [2:0]       w_rd;
  logic [2:0]       w_rs;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_carry;

  assign w_in_op  = inst_data[11:9];
  assign w_op     = r_inst[11:9];
  assign w_fn     = r_inst[8:6];
  assign w_rd     = r_inst[5:3];
  assign w_rs     = r_inst[2:0];
  assign w_accept = (r_state == S_FETCH) && inst_valid;

  assign w_b      = r_regs[w_rs];
  assign w_sum    = {1'b0, r_ra} + {1'b0, w_b};

  assign dbg_data = r_regs[dbg_sel];
  assign carry    = r_carry;
  assign zero     = r_zero;
  assign err      = r_err;

  // ALU: operand A is the RA snapshot taken in LOADA, operand B is read live
  // in EXEC. Registers are not written between LOADA and WB, so rd == rs
  // sees the pre-instruction value on both sides.
  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    case (w_fn)
      FN_ADD: begin
        w_alu_res   = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
      end
      FN_SUB: begin
        w_alu_res   = r_ra - w_b;
        w_alu_carry = (r_ra >= w_b);
      end
      FN_AND:  w_alu_res = r_ra & w_b;
      FN_OR:   w_alu_res = r_ra | w_b;
      FN_XOR:  w_alu_res = r_ra ^ w_b;
      FN_SHL: begin
        w_alu_res   = {r_ra[WIDTH-2:0], 1'b0};
        w_alu_carry = r_ra[WIDTH-1];
      end
      FN_SHR: begin
        w_alu_res   = {1'b0, r_ra[WIDTH-1:1]};
        w_alu_carry = r_ra[0];
      end
      FN_PASS: w_alu_res = w_b;
      default: w_alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    inst_ready = 1'b0;
    out_valid  = 1'b0;
    halted     = 1'b0;
    out_data   = r_regs[w_rd];
    case (r_state)
      S_FETCH: begin
        inst_ready = 1'b1;
        if (w_accept) begin
          case (w_in_op)
            OP_LDI, OP_MOV: w_next = S_WB;
            OP_ALU:         w_next = S_LOADA;
            OP_OUT:         w_next = S_OUTW;
            OP_HALT:        w_next = S_HALT;
            default:        w_next = S_FETCH;  // NOP and illegal opcodes
          endcase
        end
      end
      S_LOADA: w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_FETCH;
      S_OUTW: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        w_next = S_HALT;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst     <= '0;
      r_ra       <= '0;
      r_rc       <= '0;
      r_rc_carry <= 1'b0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_err      <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_inst <= inst_data;
        if (w_in_op[2:1] == 2'b11) begin
          r_err <= 1'b1;
        end
      end
      case (r_state)
        S_LOADA: r_ra <= r_regs[w_rd];
        S_EXEC: begin
          r_rc       <= w_alu_res;
          r_rc_carry <= w_alu_carry;
        end
        S_WB: begin
          case (w_op)
            OP_LDI: r_regs[w_rd] <= WIDTH'({r_inst[8:6], r_inst[2:0]});
            OP_MOV: r_regs[w_rd] <= r_regs[w_rs];
            OP_ALU: begin
              r_regs[w_rd] <= r_rc;
              r_carry      <= r_rc_carry;
              r_zero       <= (r_rc == '0);
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb/tb_multicycle_cpu.sv - scoreboard testbench for multicycle_cpu
module tb_multicycle_cpu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         inst_valid;
  logic [11:0]  inst_data;
  logic         inst_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         carry;
  logic         zero;
  logic         halted;
  logic         err;
  logic [2:0]   dbg_sel;
  logic [W-1:0] dbg_data;

  multicycle_cpu #(.WIDTH(W), .NREG(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .inst_ready (inst_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .carry      (carry),
    .zero       (zero),
    .halted     (halted),
    .err        (err),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  always #10 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] sb_q [$];
  logic [W-1:0] m_r [8];
  logic         m_c;
  logic         m_z;
  logic         m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // OUT results are compared in the cycle they are offered with out_ready high.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else                  check("out_data", out_data, sb_q.pop_front());
    end
  end

  function automatic logic [11:0] ldi(input int rd, input int imm);
    logic [5:0] v;
    v = 6'(imm);
    return {3'b001, v[5:3], 3'(rd), v[2:0]};
  endfunction
  function automatic logic [11:0] alu(input int fn, input int rd, input int rs);
    return {3'b011, 3'(fn), 3'(rd), 3'(rs)};
  endfunction
  function automatic logic [11:0] mov(input int rd, input int rs);
    return {3'b010, 3'b000, 3'(rd), 3'(rs)};
  endfunction
  function automatic logic [11:0] outi(input int rd);
    return {3'b100, 3'b000, 3'(rd), 3'b000};
  endfunction

  task automatic ref_alu(input int fn, input int a, input int b,
                         output logic [W-1:0] res, output logic c);
    int r;
    int md;
    md = 1 << W;
    c  = 1'b0;
    case (fn)
      0: begin r = a + b; c = (r >= md); r = r % md; end
      1: begin c = (a >= b); r = (a - b + md) % md; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin c = (a >= md / 2); r = (2 * a) % md; end
      6: begin c = (a % 2 == 1); r = a / 2; end
      default: r = b;
    endcase
    res = W'(r);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_c = 1'b0; m_z = 1'b0; m_err = 1'b0;
  endtask

  task automatic exec_model(input logic [11:0] w);
    logic [W-1:0] res;
    logic         c;
    int op, fn, rd, rs;
    op = int'(w[11:9]); fn = int'(w[8:6]); rd = int'(w[5:3]); rs = int'(w[2:0]);
    case (op)
      1: m_r[rd] = W'({w[8:6], w[2:0]});
      2: m_r[rd] = m_r[rs];
      3: begin
        ref_alu(fn, int'(m_r[rd]), int'(m_r[rs]), res, c);
        m_r[rd] = res; m_c = c; m_z = (res == '0);
      end
      4: sb_q.push_back(m_r[rd]);
      6, 7: m_err = 1'b1;
      default: ;
    endcase
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (!inst_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!inst_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [11:0] w);
    wait_ready();
    inst_data  = w;
    inst_valid = 1'b1;
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
  endtask

  task automatic run(input logic [11:0] w);
    exec_model(w);
    send(w);
  endtask

  task automatic check_all(input string tag);
    wait_ready();
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), dbg_data, m_r[i]);
    end
    check({tag, "_carry"}, carry, m_c);
    check({tag, "_zero"}, zero, m_z);
    check({tag, "_err"}, err, m_err);
  endtask

  task automatic read_reg(input int r, output logic [W-1:0] v);
    dbg_sel = 3'(r);
    #1;
    v = dbg_data;
  endtask

  initial begin
    logic [W-1:0] v;
    rst = 1'b1; inst_valid = 1'b0; inst_data = '0; out_ready = 1'b1; dbg_sel = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_inst_ready", inst_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_halted", halted, 0);
    check_all("rst");

    // LDI/LDI/ADD/OUT with write-back timing on the ADD
    run(ldi(1, 5));
    run(ldi(2, 3));
    exec_model(alu(0, 1, 2));
    send(alu(0, 1, 2));
    dbg_sel = 3'd1;
    repeat (3) @(negedge clk);
    check("add_before_wb", dbg_data, 8'h05);
    check("add_busy_ready", inst_ready, 0);
    @(negedge clk);
    check("add_after_wb", dbg_data, 8'h08);
    check("add_fetch_ready", inst_ready, 1);
    run(outi(1));
    check_all("add");
    check("add_carry_k", carry, 0);
    check("add_zero_k", zero, 0);

    // SUB with borrow, then self-subtract
    run(ldi(1, 2));
    run(ldi(2, 3));
    run(alu(1, 1, 2));
    check_all("sub1");
    read_reg(1, v);
    check("sub1_r1_k", v, 8'hFF);
    check("sub1_carry_k", carry, 0);
    run(alu(1, 2, 2));
    check_all("sub2");
    read_reg(2, v);
    check("sub2_r2_k", v, 8'h00);
    check("sub2_flags_k", {carry, zero}, 2'b11);

    // shifts then overflowing ADD with rd == rs
    run(ldi(4, 6'h3F));
    run(alu(5, 4, 4));
    run(alu(5, 4, 4));
    check_all("shl");
    read_reg(4, v);
    check("shl_r4_k", v, 8'hFC);
    check("shl_carry_k", carry, 0);
    run(alu(0, 4, 4));
    check_all("add44");
    read_reg(4, v);
    check("add44_r4_k", v, 8'hF8);
    check("add44_carry_k", carry, 1);

    // OUT with back-pressure
    out_ready = 1'b0;
    run(outi(4));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 8'hF8);
      check("bp_inst_ready", inst_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_done_valid", out_valid, 0);
    check("bp_done_ready", inst_ready, 1);

    // random mix of LDI/MOV/ALU/OUT/NOP against the model
    for (int i = 0; i < 40; i++) begin
      int kind, rd, rs;
      kind = int'($urandom_range(0, 4));
      rd = int'($urandom_range(0, 7));
      rs = int'($urandom_range(0, 7));
      case (kind)
        0: run(ldi(rd, int'($urandom_range(0, 63))));
        1: run(mov(rd, rs));
        2: run(outi(rd));
        3: run(12'h000);
        default: run(alu(int'($urandom_range(0, 7)), rd, rs));
      endcase
      if (i % 8 == 7) check_all($sformatf("rnd%0d", i));
    end

    // illegal opcodes, recovery, then HALT
    run(12'hC00);
    run(12'hE3F);
    check_all("illegal");
    check("illegal_err_k", err, 1);
    run(ldi(7, 6'h2A));
    check_all("post_illegal");
    send(12'hA00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("halt_halted", halted, 1);
      check("halt_inst_ready", inst_ready, 0);
    end

    // reset during EXEC of ADD R1,R2
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst2_halted", halted, 0);
    run(ldi(1, 5));
    run(ldi(2, 3));
    send(alu(0, 1, 2));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("rst3_inst_ready", inst_ready, 1);
    read_reg(1, v);
    check("rst3_r1", v, 8'h00);
    check("rst3_flags", {carry, zero}, 2'b00);
    check_all("rst3");
    run(ldi(3, 9));
    check_all("final");
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
